ofdm_deinterleaver: RTL and testbench
=====================================

Name: ofdm_deinterleaver

Overview:
- Receive-side 802.11a block deinterleaver; inverse of the transmit interleaver.
- Collects one OFDM symbol (NCBPS coded bits) from the demapper, bit-serial.
- Emits the bits bit-serial in original coded order to the depuncturer/Viterbi decoder.
- Ping-pong buffered: symbol n is written while symbol n-1 is read, so back-to-back symbols never stall.

Parameters:
- MAX_NCBPS, 288, bank depth in bits; must be >= 288.
- SOFT_W, 3, soft-bit width; used only when DEINT_SOFT_EN is defined.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- inputData  in  1 (SOFT_W with DEINT_SOFT_EN)  received coded bit, in interleaved order.
- inputValid  in  1  qualifies inputData; gaps allowed.
- mode  in  2  00 BPSK/48, 01 QPSK/96, 10 16QAM/192, 11 64QAM/288.
- outputData  out  1 (SOFT_W)  deinterleaved bit.
- outputValid  out  1  qualifies outputData.
- outputLast  out  1  high with the final bit (k = NCBPS-1) of each symbol.

Behaviour:
- Reset (reset==0 at an edge):
  - outputData, outputValid and outputLast = 0.
  - Write counter j = 0; both banks marked empty; write bank = 0.
  - Partial symbols are discarded.
  - Reset has priority over every other event.
- Mode capture:
  - mode is sampled on the first valid bit of a symbol (j == 0).
  - The captured mode is held until j wraps.
  - mode changes mid-symbol are ignored.
- Derived constants from the captured mode:
  - NCBPS = 48/96/192/288.
  - D = NCBPS/16 = 3/6/12/18.
  - s = 1/1/2/3.
- Write side:
  - On each inputValid, the bit with received index j is written at address k(j) of the write bank, and j increments.
  - When j == NCBPS-1 is written: j wraps to 0, the bank is marked full and handed to the read side, and the write bank toggles.
- Index map (exact integer arithmetic, no run-time divider):
  - q = floor(j/D)
  - i = s*floor(j/s) + ((j + q) mod s)
  - k = 16*(i mod D) + floor(i/D)
  - Implemented with incremental counters (j mod D, q, j mod s) stepped per accepted bit.
  - Widths: j, i, k are 9 bits; no intermediate wider than 9 bits is needed.
- Read side:
  - Two states, IDLE and READ.
  - IDLE -> READ the cycle after a bank becomes full.
  - In READ: outputs address r = 0..NCBPS-1 of that bank, one bit per cycle, outputValid = 1 continuously.
  - outputLast = 1 at r = NCBPS-1.
  - After the last bit: go to READ on the next symbol if the other bank is already full (no bubble); otherwise go to IDLE with outputValid = 0 and outputData = 0.
- Latency: first output bit appears 2 cycles after the edge that accepts the last input bit of the symbol.
- Overlap:
  - Input rate is at most 1 bit/cycle and the read drains a bank in NCBPS cycles, so the write side can never catch the unread bank.
  - A write completing in the same cycle as a read finishing is legal: the new bank is queued, then read back-to-back.
- No flush: an incomplete trailing symbol is never output.

Optional Feature:
- Macro: DEINT_SOFT_EN.
- Defined:
  - inputData and outputData are SOFT_W bits wide (signed soft metrics for soft Viterbi).
  - Banks are MAX_NCBPS x SOFT_W.
  - Permutation and timing are identical to the hard-bit build.
- Undefined: 1-bit hard decisions; banks are MAX_NCBPS x 1.

Decomposition:
- Shared package ofdm_pkg:
  - mode encodings.
  - NCBPS, D and s lookup constants per mode.
  - MAX_NCBPS.
  - The same tables serve the transmit interleaver.
- One sub-module, deint_index_gen:
  - Incremental generator producing k(j) from captured mode, clear and step inputs.
  - Reusable in reverse for a bench reference model.
- Bank storage and the read FSM stay in the top module.

Test Plan:
- BPSK, one symbol of all zeros except a single 1 at received index j=1 -> single 1 at output index 16; outputLast at output index 47; outputValid high for exactly 48 consecutive cycles starting 2 cycles after the last input.
- 16QAM, single 1 at j=13 -> output index 1; single 1 at j=1 -> output index 16; 192-bit output burst.
- 64QAM, single 1 at j=18 -> output index 17; burst length 288.
- Round trip: random 96-bit QPSK payloads through transmit interleaver then this block, 4 back-to-back symbols with continuous inputValid -> output equals payload, no outputValid gap between symbols.
- inputValid toggling 1-on/1-off through a 48-bit symbol, plus a mode change at j=20 -> mode ignored, still a 48-bit burst, correct order.
- Reset pulled low at j=30 of a symbol, then one full 48-bit symbol -> outputs 0 during reset; only the second symbol is emitted, correct.

Source files
------------

// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - 802.11a interleaver mode encodings and per-mode constants
package ofdm_pkg;

  localparam int MAX_NCBPS = 288;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_16QAM = 2'b10,
    MODE_64QAM = 2'b11
  } mode_e;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  // Coded bits per OFDM symbol.
  function automatic logic [8:0] ncbps_of(mode_e m);
    case (m)
      MODE_BPSK:  return 9'd48;
      MODE_QPSK:  return 9'd96;
      MODE_16QAM: return 9'd192;
      default:    return 9'd288;
    endcase
  endfunction

  // Column depth D = NCBPS/16.
  function automatic logic [4:0] d_of(mode_e m);
    case (m)
      MODE_BPSK:  return 5'd3;
      MODE_QPSK:  return 5'd6;
      MODE_16QAM: return 5'd12;
      default:    return 5'd18;
    endcase
  endfunction

  // Bit-rotation group size s = max(NBPSC/2, 1).
  function automatic logic [1:0] s_of(mode_e m);
    case (m)
      MODE_BPSK:  return 2'd1;
      MODE_QPSK:  return 2'd1;
      MODE_16QAM: return 2'd2;
      default:    return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/deint_index_gen.sv
// rtl/deint_index_gen.sv - incremental generator of deinterleaver write address k(j)
// D is a multiple of s, so an s-group never straddles a column: i mod D = jm - js + t, floor(i/D) = q.
module deint_index_gen import ofdm_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  input  mode_e      mode,
  output logic [8:0] k
);

  logic [4:0] jm;
  logic [3:0] q;
  logic [1:0] js;
  logic [1:0] qs;
  logic [4:0] d;
  logic [1:0] s;
  logic [2:0] t_sum;
  logic [2:0] t_wrap;
  logic [1:0] t;
  logic [4:0] imod;

  always_comb begin
    d      = d_of(mode);
    s      = s_of(mode);
    t_sum  = {1'b0, js} + {1'b0, qs};
    t_wrap = t_sum - {1'b0, s};
    t      = (t_sum >= {1'b0, s}) ? t_wrap[1:0] : t_sum[1:0];
    imod   = jm - {3'b000, js} + {3'b000, t};
    k      = {imod, q};
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      jm <= '0;
      q  <= '0;
      js <= '0;
      qs <= '0;
    end else if (step) begin
      js <= (js == s - 2'd1) ? 2'd0 : js + 2'd1;
      if (jm == d - 5'd1) begin
        jm <= '0;
        q  <= q + 4'd1;
        qs <= (qs == s - 2'd1) ? 2'd0 : qs + 2'd1;
      end else begin
        jm <= jm + 5'd1;
      end
    end
  end

endmodule

// File: rtl/ofdm_deinterleaver.sv
// rtl/ofdm_deinterleaver.sv - ping-pong 802.11a block deinterleaver, bit-serial in and out
// DEINT_SOFT_EN selects SOFT_W-bit soft metrics instead of hard bits.
module ofdm_deinterleaver #(
  parameter int MAX_NCBPS = 288
`ifdef DEINT_SOFT_EN
  , parameter int SOFT_W = 3
`endif
) (
  input  logic              clock,
  input  logic              reset,
`ifdef DEINT_SOFT_EN
  input  logic [SOFT_W-1:0] inputData,
`else
  input  logic              inputData,
`endif
  input  logic              inputValid,
  input  logic [1:0]        mode,
`ifdef DEINT_SOFT_EN
  output logic [SOFT_W-1:0] outputData,
`else
  output logic              outputData,
`endif
  output logic              outputValid,
  output logic              outputLast
);
  import ofdm_pkg::*;

`ifdef DEINT_SOFT_EN
  localparam int DW = SOFT_W;
`else
  localparam int DW = 1;
`endif

  logic [DW-1:0] bank0 [MAX_NCBPS];
  logic [DW-1:0] bank1 [MAX_NCBPS];
  mode_e         bank_mode [2];

  logic [8:0] j;
  logic [8:0] k;
  logic [8:0] wr_n;
  mode_e      cap_mode;
  mode_e      eff_mode;
  logic       wbank;
  logic       wr_last;
  logic [1:0] full;

  rd_state_e  state, state_n;
  logic       rbank, rbank_n;
  logic [8:0] r, r_n;
  logic [8:0] rd_n;
  logic       rd_done;

  // The first bit of a symbol takes the live mode; the rest use the captured one.
  always_comb begin
    eff_mode = (j == 9'd0) ? mode_e'(mode) : cap_mode;
    wr_n     = ncbps_of(eff_mode);
    wr_last  = inputValid && (j == wr_n - 9'd1);
    rd_n     = ncbps_of(bank_mode[rbank]);
  end

  deint_index_gen u_index_gen (
    .clock (clock),
    .reset (reset),
    .clear (wr_last),
    .step  (inputValid),
    .mode  (eff_mode),
    .k     (k)
  );

  always_ff @(posedge clock) begin
    if (reset && inputValid) begin
      if (wbank) bank1[k] <= inputData;
      else       bank0[k] <= inputData;
      if (wr_last) bank_mode[wbank] <= eff_mode;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      j        <= '0;
      wbank    <= 1'b0;
      full     <= 2'b00;
      cap_mode <= MODE_BPSK;
    end else begin
      if (inputValid) begin
        if (j == 9'd0) cap_mode <= eff_mode;
        if (wr_last) begin
          j     <= '0;
          wbank <= ~wbank;
        end else begin
          j <= j + 9'd1;
        end
      end
      if (rd_done) full[rbank] <= 1'b0;
      if (wr_last) full[wbank] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RD_IDLE;
      rbank <= 1'b0;
      r     <= '0;
    end else begin
      state <= state_n;
      rbank <= rbank_n;
      r     <= r_n;
    end
  end

  // A bank finishing on the same edge as the current read ends chains straight on.
  always_comb begin
    state_n = state;
    rbank_n = rbank;
    r_n     = r;
    rd_done = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rbank]) begin
          state_n = RD_READ;
          r_n     = '0;
        end
      end
      RD_READ: begin
        if (r == rd_n - 9'd1) begin
          rd_done = 1'b1;
          rbank_n = ~rbank;
          r_n     = '0;
          if (!(full[~rbank] || (wr_last && (wbank != rbank)))) state_n = RD_IDLE;
        end else begin
          r_n = r + 9'd1;
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset || (state != RD_READ)) begin
      outputData  <= '0;
      outputValid <= 1'b0;
      outputLast  <= 1'b0;
    end else begin
      outputData  <= rbank ? bank1[r] : bank0[r];
      outputValid <= 1'b1;
      outputLast  <= (r == rd_n - 9'd1);
    end
  end

endmodule

// File: tb/tb_ofdm_deinterleaver.sv
// tb/tb_ofdm_deinterleaver.sv - directed self-checking bench for ofdm_deinterleaver
module tb_ofdm_deinterleaver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       inputData = 1'b0;
  logic       inputValid = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       outputData;
  logic       outputValid;
  logic       outputLast;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;

  logic out_d[$];
  logic out_l[$];
  int   out_c[$];
  logic tx_bits[1152];
  logic pay[1152];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (outputValid === 1'b1) begin
      out_d.push_back(outputData);
      out_l.push_back(outputLast);
      out_c.push_back(cyc);
    end
  end

  ofdm_deinterleaver dut (
    .clock       (clock),
    .reset       (reset),
    .inputData   (inputData),
    .inputValid  (inputValid),
    .mode        (mode),
    .outputData  (outputData),
    .outputValid (outputValid),
    .outputLast  (outputLast)
  );

  function automatic int ncbps_m(int m);
    return (m == 0) ? 48 : (m == 1) ? 96 : (m == 2) ? 192 : 288;
  endfunction

  // Forward 802.11a interleaver: coded index k -> transmitted index j.
  function automatic int tx_j(int m, int k);
    int n, s, i;
    n = ncbps_m(m);
    s = (m == 3) ? 3 : (m == 2) ? 2 : 1;
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  task automatic clear_q();
    out_d.delete();
    out_l.delete();
    out_c.delete();
  endtask

  task automatic drive_bits(input int m, input int n, input int gap, input int chg_at, input int chg_m);
    for (int j = 0; j < n; j++) begin
      mode       = (j >= chg_at) ? 2'(chg_m) : 2'(m);
      inputData  = tx_bits[j];
      inputValid = 1'b1;
      @(posedge clock); #1;
      last_acc = cyc;
      if (gap != 0) begin
        inputValid = 1'b0;
        inputData  = 1'b1;
        @(posedge clock); #1;
      end
    end
    inputValid = 1'b0;
    inputData  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 3000 && out_d.size() < n; t++) @(posedge clock);
    repeat (6) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    inputValid = 1'b1;
    inputData = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (outputValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", outputValid); end
    checks++; if (outputData !== 1'b0) begin fails++; $display("FAIL reset_data: got %b expected 0", outputData); end
    checks++; if (outputLast !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", outputLast); end
    inputValid = 1'b0;
    inputData = 1'b0;
    reset = 1'b1;
    clear_q();
    repeat (60) @(posedge clock);
    #1;
    checks++; if (out_d.size() !== 0) begin fails++; $display("FAIL reset_idle: got %0d outputs expected 0", out_d.size()); end
  endtask

  task automatic test_single_one(input string name, input int m, input int jin, input int kexp);
    int n, ones, pos, lasts, lpos, first_c, end_c;
    n = ncbps_m(m);
    clear_q();
    for (int j = 0; j < n; j++) tx_bits[j] = 1'b0;
    tx_bits[jin] = 1'b1;
    drive_bits(m, n, 0, n, m);
    wait_out(n);
    ones = 0; pos = -1; lasts = 0; lpos = -1;
    for (int x = 0; x < out_d.size(); x++) begin
      if (out_d[x] === 1'b1) begin ones++; if (pos < 0) pos = x; end
      if (out_l[x] === 1'b1) begin lasts++; lpos = x; end
    end
    first_c = (out_c.size() > 0) ? out_c[0] : -1;
    end_c   = (out_c.size() > 0) ? out_c[out_c.size()-1] : -1;
    checks++; if (out_d.size() !== n) begin fails++; $display("FAIL %s burst_len: got %0d expected %0d", name, out_d.size(), n); end
    checks++; if (pos !== kexp) begin fails++; $display("FAIL %s one_pos: got %0d expected %0d", name, pos, kexp); end
    checks++; if (ones !== 1) begin fails++; $display("FAIL %s one_count: got %0d expected 1", name, ones); end
    checks++; if (lpos !== n - 1 || lasts !== 1) begin fails++; $display("FAIL %s last: got pos %0d count %0d expected pos %0d count 1", name, lpos, lasts, n - 1); end
    checks++; if (first_c !== last_acc + 2) begin fails++; $display("FAIL %s latency: got cycle %0d expected %0d", name, first_c, last_acc + 2); end
    checks++; if (end_c - first_c !== n - 1) begin fails++; $display("FAIL %s contiguous: got span %0d expected %0d", name, end_c - first_c, n - 1); end
  endtask

  task automatic test_back_to_back();
    int first_c, end_c;
    clear_q();
    for (int sy = 0; sy < 4; sy++)
      for (int k = 0; k < 96; k++) begin
        pay[sy*96 + k] = 1'($urandom_range(0, 1));
        tx_bits[sy*96 + tx_j(1, k)] = pay[sy*96 + k];
      end
    drive_bits(1, 384, 0, 384, 1);
    wait_out(384);
    checks++; if (out_d.size() !== 384) begin fails++; $display("FAIL b2b_len: got %0d expected 384", out_d.size()); end
    for (int x = 0; x < 384 && x < out_d.size(); x++) begin
      checks++; if (out_d[x] !== pay[x]) begin fails++; $display("FAIL b2b_data[%0d]: got %b expected %b", x, out_d[x], pay[x]); end
      checks++; if (out_l[x] !== ((x % 96) == 95)) begin fails++; $display("FAIL b2b_last[%0d]: got %b expected %b", x, out_l[x], (x % 96) == 95); end
    end
    first_c = (out_c.size() > 0) ? out_c[0] : -1;
    end_c   = (out_c.size() > 0) ? out_c[out_c.size()-1] : -1;
    checks++; if (end_c - first_c !== 383) begin fails++; $display("FAIL b2b_no_gap: got span %0d expected 383", end_c - first_c); end
  endtask

  task automatic test_gaps_mode_change();
    clear_q();
    for (int k = 0; k < 48; k++) begin
      pay[k] = 1'($urandom_range(0, 1));
      tx_bits[tx_j(0, k)] = pay[k];
    end
    drive_bits(0, 48, 1, 20, 3);
    wait_out(48);
    checks++; if (out_d.size() !== 48) begin fails++; $display("FAIL gap_len: got %0d expected 48", out_d.size()); end
    for (int x = 0; x < 48 && x < out_d.size(); x++) begin
      checks++; if (out_d[x] !== pay[x]) begin fails++; $display("FAIL gap_data[%0d]: got %b expected %b", x, out_d[x], pay[x]); end
    end
    checks++; if (out_d.size() > 47 && out_l[47] !== 1'b1) begin fails++; $display("FAIL gap_last: got %b expected 1", out_l[47]); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    for (int j = 0; j < 30; j++) tx_bits[j] = 1'($urandom_range(0, 1));
    drive_bits(0, 30, 0, 30, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checks++; if ({outputValid, outputData, outputLast} !== 3'b000) begin fails++; $display("FAIL mid_reset_out: got %b expected 000", {outputValid, outputData, outputLast}); end
    end
    reset = 1'b1;
    for (int k = 0; k < 48; k++) begin
      pay[k] = 1'($urandom_range(0, 1));
      tx_bits[tx_j(0, k)] = pay[k];
    end
    drive_bits(0, 48, 0, 48, 0);
    wait_out(48);
    checks++; if (out_d.size() !== 48) begin fails++; $display("FAIL mid_len: got %0d expected 48", out_d.size()); end
    for (int x = 0; x < 48 && x < out_d.size(); x++) begin
      checks++; if (out_d[x] !== pay[x]) begin fails++; $display("FAIL mid_data[%0d]: got %b expected %b", x, out_d[x], pay[x]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_one("bpsk_j1", 0, 1, 16);
    test_single_one("qam16_j13", 2, 13, 1);
    test_single_one("qam16_j1", 2, 1, 16);
    test_single_one("qam64_j18", 3, 18, 17);
    test_back_to_back();
    test_gaps_mode_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
